// File: rtl/regfile_multiport_if.sv
// regfile_multiport_if: read, write and debug-dump bus of the multiport register file
interface regfile_multiport_if #(
  parameter int B  = 32,
  parameter int W  = 5,
  parameter int NR = 2
);
  logic            wr_en;
  logic [W-1:0]    w_addr;
  logic [B-1:0]    w_data;
  logic [NR*W-1:0] r_addr;
  logic [NR*B-1:0] r_data;
  logic            dbg_start;
  logic            dbg_ready;
  logic            dbg_valid;
  logic [W-1:0]    dbg_addr;
  logic [B-1:0]    dbg_data;
  logic            dbg_busy;
  logic            dbg_done;
  modport master (
    output wr_en, w_addr, w_data, r_addr, dbg_start, dbg_ready,
    input  r_data, dbg_valid, dbg_addr, dbg_data, dbg_busy, dbg_done
  );
  modport slave (
    input  wr_en, w_addr, w_data, r_addr, dbg_start, dbg_ready,
    output r_data, dbg_valid, dbg_addr, dbg_data, dbg_busy, dbg_done
  );
endinterface

// File: rtl/regfile_multiport.sv
// regfile_multiport: 2**W x B register file (r0 = 0), NR async read ports, one write port, debug dump streamer; define REGFILE_BYPASS_EN for write-first forwarding
module regfile_multiport #(
  parameter int B  = 32,
  parameter int W  = 5,
  parameter int NR = 2
) (
  input logic clk,
  input logic reset,
  regfile_multiport_if.slave bus
);
  localparam int N = 1 << W;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t       state, state_n;
  logic [W-1:0] idx, idx_n;
  logic [B-1:0] regs [N];
  function automatic logic [B-1:0] rd(input logic [W-1:0] a);
`ifdef REGFILE_BYPASS_EN
    return a == '0 ? '0 : (bus.wr_en && bus.w_addr == a) ? bus.w_data : regs[a];
`else
    return a == '0 ? '0 : regs[a];
`endif
  endfunction
  // register array: async clear, one write port, r0 is never written
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < N; i++) regs[i] <= '0;
    else if (bus.wr_en && bus.w_addr != '0) regs[bus.w_addr] <= bus.w_data;
  // independent combinational read ports
  always_comb begin
    bus.r_data = '0;
    for (int k = 0; k < NR; k++) bus.r_data[k*B +: B] = rd(bus.r_addr[k*W +: W]);
  end
  // dump FSM state and scan index
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  // next state: leave SCAN on acceptance of the last index, never wrap idx
  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      IDLE: if (bus.dbg_start) begin
        state_n = SCAN;
        idx_n   = '0;
      end
      SCAN: if (bus.dbg_ready) begin
        state_n = idx == '1 ? DONE : SCAN;
        idx_n   = idx == '1 ? idx : idx + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  // dump outputs: dbg_data is a live read so a stalled word follows writes to it
  always_comb begin
    bus.dbg_valid = state == SCAN;
    bus.dbg_busy  = state != IDLE;
    bus.dbg_done  = state == DONE;
    bus.dbg_addr  = state == SCAN ? idx : '0;
    bus.dbg_data  = state == SCAN ? rd(idx) : '0;
  end
endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor of the ID-stage general-purpose register file.
- Register count is exactly 2**W. Register 0 is hard-wired to zero.
- NR combinational read ports, one synchronous write port, and asynchronous clear of all registers on reset.
- Adds a sequential debug dump channel: a valid/ready streamer that walks every register so the debug unit can ship the register contents off-chip.

Parameters:
- B, 32, data word width in bits.
- W, 5, address width; depth = 2**W registers.
- NR, 2, number of read ports (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears registers and debug FSM.
- wr_en  input  1  write enable, sampled on rising clk.
- w_addr  input  W  write address.
- w_data  input  B  write data.
- r_addr  input  NR*W  flattened read addresses; port k = bits [k*W +: W].
- r_data  output  NR*B  flattened read data; port k = bits [k*B +: B].
- dbg_start  input  1  one-cycle request to begin a dump.
- dbg_ready  input  1  consumer accepts current dump word.
- dbg_valid  output  1  dump word present.
- dbg_addr  output  W  register index of current dump word.
- dbg_data  output  B  contents of register dbg_addr.
- dbg_busy  output  1  high in SCAN and DONE.
- dbg_done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (async, any time):
  - All 2**W registers go to 0.
  - FSM goes to IDLE.
  - dbg_valid, dbg_busy and dbg_done are 0; dbg_addr is 0.
  - A reset during a scan aborts the scan; no dbg_done pulse is produced.
- Write:
  - If wr_en=1 and w_addr!=0, reg[w_addr] <= w_data on the rising edge.
  - A write to address 0 is discarded.
- Read:
  - Purely combinational: r_data[k] = (r_addr[k]==0) ? 0 : reg[r_addr[k]].
  - All ports are independent; any ports may present the same address.
- Same-cycle read/write of the same non-zero address: see Optional Feature.
- Debug FSM, states IDLE, SCAN, DONE; internal index idx is W bits wide:
  - IDLE: dbg_start=1 -> SCAN, idx=0. dbg_start is ignored in SCAN and DONE.
  - SCAN:
    - Outputs: dbg_valid=1, dbg_addr=idx, dbg_data=live read of reg[idx], with reg 0 reading as 0.
    - On dbg_valid&&dbg_ready: if idx==2**W-1 go to DONE, else idx<=idx+1.
    - With dbg_ready=0, all dbg outputs hold. Exception: dbg_data tracks a write to reg[idx] landing in the stall cycle.
  - DONE: dbg_done=1 for exactly one cycle, dbg_valid=0, then IDLE.
  - Wrap-around: idx never exceeds 2**W-1; the exit to DONE happens before any increment past the last index.
- The scan never blocks or delays the normal read and write ports.
- Minimum dump length is 2**W cycles plus 1 DONE cycle when dbg_ready is held high.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-first forwarding):
  - If wr_en=1, w_addr!=0 and r_addr[k]==w_addr, then r_data[k]=w_data in the same cycle.
  - The same forwarding applies to dbg_data when dbg_addr==w_addr.
- Undefined:
  - A same-cycle read returns the old contents; the new value is visible from the next cycle.
- Address 0 always reads 0 in both builds.

Test Plan:
- Reset then read: assert reset, release; read r_addr=3 and 31 -> r_data=0x00000000 on both ports.
- Write/read: write 0xDEADBEEF to reg 5, next cycle read port0=5, port1=5 -> both 0xDEADBEEF.
- R0 protection: write 0x12345678 to reg 0 -> read of reg 0 returns 0.
- Same-cycle hazard: write 0xA5A5A5A5 to reg 7 while reading reg 7 (old value 0x11):
  - Bypass build returns 0xA5A5A5A5 that cycle.
  - Non-bypass build returns 0x00000011 that cycle and 0xA5A5A5A5 the next.
- Full dump with backpressure:
  - Preload reg i = i*0x100 for i=1..31.
  - Pulse dbg_start; toggle dbg_ready 1/0 each cycle.
  - Expect 32 accepted words: addr 0..31 in order, data 0, 0x100, ..., 0x1F00.
  - Outputs stay stable while dbg_ready=0.
  - Exactly one dbg_done pulse after addr 31 is accepted.
  - dbg_start pulses mid-scan are ignored.
- Reset mid-scan: assert reset while dbg_addr=10 -> dbg_valid=0 and dbg_busy=0 immediately, no dbg_done; a subsequent dump reads all zeros.
